// File: rtl/fpga_tick_pkg.sv
// Purpose: shared constants and the divisor sanitise helper for the tick divider.
// Latency: n/a (package, pure combinational helper).
// Backpressure: n/a.
package fpga_tick_pkg;

  // Widest counter the sanitise helper handles; channel widths must not exceed it.
  localparam int MaxCntWidth = 32;

  // Smallest divisor that still yields one low and one high cycle.
  localparam int MinDiv = 2;

  // Raise divisors below MinDiv to MinDiv; everything else passes through untouched.
  function automatic logic [MaxCntWidth-1:0] sanitise_div(input logic [MaxCntWidth-1:0] d);
    return (d < MaxCntWidth'(MinDiv)) ? MaxCntWidth'(MinDiv) : d;
  endfunction

endpackage

// File: rtl/fpga_tick_divider_if.sv
// Purpose: bundles the per-channel control, divisor write handshake and divided outputs.
// Latency: n/a (wires only).
// Backpressure: div_ready_o is the only flow-control signal; it is low only during reset.
//
// master: the controller programming the divider (drives enables, divisors, sync).
// slave : the divider itself.
interface fpga_tick_divider_if #(
  parameter int NumChannels = 2,
  parameter int CntWidth    = 16
) ();

  logic [NumChannels-1:0]               en_i;
  logic [NumChannels-1:0][CntWidth-1:0] div_i;
  logic [NumChannels-1:0]               div_valid_i;
  logic [NumChannels-1:0]               div_ready_o;
  logic                                 sync_i;
  logic [NumChannels-1:0]               clk_o;
  logic [NumChannels-1:0]               tick_o;
  logic [NumChannels-1:0][CntWidth-1:0] active_div_o;

  modport master (
    output en_i, div_i, div_valid_i, sync_i,
    input  div_ready_o, clk_o, tick_o, active_div_o
  );

  modport slave (
    input  en_i, div_i, div_valid_i, sync_i,
    output div_ready_o, clk_o, tick_o, active_div_o
  );

endinterface

// File: rtl/fpga_tick_div_chan.sv
// Purpose: one divider channel: counter, shadow/pending divisor, active divisor, clk/tick flops.
// Latency: clk/tick are registered from the next counter value; a write takes effect at the
//          next wrap, sync, or immediately on the next cycle while disabled.
// Backpressure: div_ready is low only during reset; writes are never stalled afterwards.
//
// Ports: clk_i/rst_ni clock and async active-low reset; en level enable; div/div_valid/div_ready
//        divisor write handshake; sync phase-realign pulse; clk_div divided square wave;
//        tick one-cycle pulse at the start of the high phase; active_div divisor in effect.
module fpga_tick_div_chan
  import fpga_tick_pkg::*;
#(
  parameter int CntWidth   = 16,
  parameter int DefaultDiv = 50
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en,
  input  logic [CntWidth-1:0] div,
  input  logic                div_valid,
  input  logic                sync,
  output logic                div_ready,
  output logic                clk_div,
  output logic                tick,
  output logic [CntWidth-1:0] active_div
);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] act_q, act_d;
  logic [CntWidth-1:0] shd_q, shd_d;
  logic                pend_q, pend_d;
  logic                rdy_q;
  logic                clk_q, clk_d;
  logic                tick_q, tick_d;

  logic                wr;
  logic [CntWidth-1:0] wr_val;
  logic                wrap;
  logic                restart;
  logic [CntWidth-1:0] low_d;

  always_comb begin
    wr      = div_valid && rdy_q;
    wr_val  = CntWidth'(sanitise_div(MaxCntWidth'(div)));
    // Compare against D-1 explicitly so the wrap never depends on counter overflow.
    wrap    = (cnt_q == (act_q - CntWidth'(1)));
    // Every case that lands the counter on 0 is also a point where a pending divisor
    // may be applied: disabled, sync, or the natural end of a period.
    restart = !en || sync || wrap;

    // A write in the same cycle as a restart is folded in, so it is applied right away.
    shd_d  = wr ? wr_val : shd_q;
    pend_d = pend_q || wr;
    act_d  = act_q;
    if (restart && pend_d) begin
      act_d  = shd_d;
    end
    if (restart) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end else begin
      cnt_d  = cnt_q + CntWidth'(1);
    end

    // Low phase is the ceiling half, so odd divisors get the extra low cycle.
    low_d  = act_d - (act_d >> 1);
    clk_d  = en && (cnt_d >= low_d);
    tick_d = en && (cnt_d == low_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      act_q  <= CntWidth'(DefaultDiv);
      shd_q  <= CntWidth'(DefaultDiv);
      pend_q <= 1'b0;
      rdy_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      rdy_q  <= 1'b1;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign div_ready  = rdy_q;
  assign clk_div    = clk_q;
  assign tick       = tick_q;
  assign active_div = act_q;

endmodule

// File: rtl/fpga_tick_divider.sv
// Purpose: multi-channel runtime-programmable clock/tick divider with shared phase sync.
// Latency: outputs are flops; divisor writes take effect at the next wrap/sync, or next cycle
//          on a disabled channel.
// Backpressure: div_ready_o is low during reset and constant high afterwards.
//
// Ports: clk_i SoC clock; rst_ni async active-low reset; bus (slave) carries en_i, div_i,
//        div_valid_i/div_ready_o, sync_i, clk_o, tick_o and active_div_o for all channels.
module fpga_tick_divider
  import fpga_tick_pkg::*;
#(
  parameter int NumChannels = 2,
  parameter int CntWidth    = 16,
  parameter int DefaultDiv  = 50
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fpga_tick_divider_if.slave  bus
);

  // Guard against a too-small reset divisor the same way runtime writes are guarded.
  localparam int ResetDiv = (DefaultDiv < MinDiv) ? MinDiv : DefaultDiv;

  logic [NumChannels-1:0]               ready;
  logic [NumChannels-1:0]               clk_div;
  logic [NumChannels-1:0]               tick;
  logic [NumChannels-1:0][CntWidth-1:0] active_div;

  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    fpga_tick_div_chan #(
      .CntWidth   (CntWidth),
      .DefaultDiv (ResetDiv)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en         (bus.en_i[g]),
      .div        (bus.div_i[g]),
      .div_valid  (bus.div_valid_i[g]),
      .sync       (bus.sync_i),
      .div_ready  (ready[g]),
      .clk_div    (clk_div[g]),
      .tick       (tick[g]),
      .active_div (active_div[g])
    );
  end

  assign bus.div_ready_o  = ready;
  assign bus.clk_o        = clk_div;
  assign bus.tick_o       = tick;
  assign bus.active_div_o = active_div;

endmodule

// File: tb/tb_fpga_tick_divider.sv
// Purpose: self-checking bench for fpga_tick_divider with directed vectors and corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_fpga_tick_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  always #5 clk = ~clk;

  fpga_tick_divider_if #(.NumChannels(2), .CntWidth(16)) bus ();

  fpga_tick_divider #(
    .NumChannels (2),
    .CntWidth    (16),
    .DefaultDiv  (50)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [15:0] d0;    // divisor written to ch0
    logic [15:0] d1;    // divisor written to ch1
    int          exp0;  // expected active divisor ch0
    int          l0;    // expected low-phase length ch0
    int          exp1;
    int          l1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int got, input int exp);
    tot_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Disable both channels, write divisors on the channels in mask, leave them disabled.
  task automatic program_div(input logic [1:0] mask, input logic [15:0] d0, input logic [15:0] d1);
    bus.en_i = 2'b00;
    step();
    bus.div_i[0] = d0;
    bus.div_i[1] = d1;
    bus.div_valid_i = mask;
    step();
    bus.div_valid_i = 2'b00;
    step();
  endtask

  // Sample n cycles starting at counter 0 and compare clk/tick against period d, low length l.
  task automatic check_both(input int n, input int d0, input int l0, input int d1, input int l1,
                            input logic [1:0] m, input string name);
    int ec0 = 0, et0 = 0, ec1 = 0, et1 = 0;
    for (int k = 0; k < n; k++) begin
      if (bus.clk_o[0]  !== ((k % d0) >= l0)) ec0++;
      if (bus.tick_o[0] !== ((k % d0) == l0)) et0++;
      if (bus.clk_o[1]  !== ((k % d1) >= l1)) ec1++;
      if (bus.tick_o[1] !== ((k % d1) == l1)) et1++;
      step();
    end
    if (m[0]) begin
      chk({name, " ch0 clk errs"}, ec0, 0);
      chk({name, " ch0 tick errs"}, et0, 0);
    end
    if (m[1]) begin
      chk({name, " ch1 clk errs"}, ec1, 0);
      chk({name, " ch1 tick errs"}, et1, 0);
    end
  endtask

  // ch0 at D=50; write v1 at counter k1 and v2 at k2 (k<0 = no write); expect exp_d after wrap.
  task automatic mid_run(input int k1, input int v1, input int k2, input int v2,
                         input int exp_d, input int exp_l, input string name);
    int e_old = 0, e_new = 0;
    program_div(2'b01, 16'd50, 16'd0);
    bus.en_i = 2'b01;
    for (int k = 0; k < 62; k++) begin
      if (k < 50) begin
        if (bus.clk_o[0] !== ((k % 50) >= 25)) e_old++;
        if (bus.tick_o[0] !== (k == 25)) e_old++;
      end else begin
        if (bus.clk_o[0] !== (((k - 50) % exp_d) >= exp_l)) e_new++;
        if (bus.tick_o[0] !== (((k - 50) % exp_d) == exp_l)) e_new++;
      end
      if (k == 49) chk({name, " active before wrap"}, int'(bus.active_div_o[0]), 50);
      if (k == 50) chk({name, " active after wrap"}, int'(bus.active_div_o[0]), exp_d);
      bus.div_valid_i[0] = (k == k1) || (k == k2);
      bus.div_i[0] = (k == k1) ? 16'(v1) : 16'(v2);
      step();
    end
    bus.div_valid_i = 2'b00;
    chk({name, " old period errs"}, e_old, 0);
    chk({name, " new period errs"}, e_new, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d0: 16'd5,  d1: 16'd7,   exp0: 5, l0: 3, exp1: 7,   l1: 4};
    vecs[1] = '{d0: 16'd0,  d1: 16'd1,   exp0: 2, l0: 1, exp1: 2,   l1: 1};
    vecs[2] = '{d0: 16'd2,  d1: 16'd4,   exp0: 2, l0: 1, exp1: 4,   l1: 2};
    vecs[3] = '{d0: 16'd3,  d1: 16'd100, exp0: 3, l0: 2, exp1: 100, l1: 50};
    vecs[4] = '{d0: 16'd6,  d1: 16'd9,   exp0: 6, l0: 3, exp1: 9,   l1: 5};
    vecs[5] = '{d0: 16'd11, d1: 16'd2,   exp0: 11, l0: 6, exp1: 2,  l1: 1};

    bus.en_i = 2'b11;
    bus.div_i = '0;
    bus.div_valid_i = 2'b00;
    bus.sync_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset clk_o", int'(bus.clk_o), 0);
    chk("reset tick_o", int'(bus.tick_o), 0);
    chk("reset active ch0", int'(bus.active_div_o[0]), 50);
    chk("reset active ch1", int'(bus.active_div_o[1]), 50);
    chk("reset ready", int'(bus.div_ready_o), 0);
    rst_n = 1'b1;
    // Default divisor 50: 25 low, 25 high, tick at count 25
    check_both(100, 50, 25, 50, 25, 2'b11, "default");
    chk("ready after reset", int'(bus.div_ready_o), 3);

    // Table-driven divisor patterns, including the clamp of 0 and 1 to 2
    foreach (vecs[i]) begin
      int n;
      n = 2 * ((vecs[i].exp0 > vecs[i].exp1) ? vecs[i].exp0 : vecs[i].exp1);
      program_div(2'b11, vecs[i].d0, vecs[i].d1);
      chk($sformatf("vec%0d active ch0", i), int'(bus.active_div_o[0]), vecs[i].exp0);
      chk($sformatf("vec%0d active ch1", i), int'(bus.active_div_o[1]), vecs[i].exp1);
      bus.en_i = 2'b11;
      check_both(n, vecs[i].exp0, vecs[i].l0, vecs[i].exp1, vecs[i].l1, 2'b11,
                 $sformatf("vec%0d", i));
    end

    // Mid-period updates: plain, last-write-wins, write coinciding with the wrap
    mid_run(10, 4, -1, 0, 4, 2, "mid write 4");
    mid_run(10, 4, 20, 6, 6, 3, "mid write 4 then 6");
    mid_run(10, 4, 49, 6, 6, 3, "write at wrap");

    // Disable in the high phase, then re-enable from count 0
    program_div(2'b01, 16'd50, 16'd0);
    bus.en_i = 2'b01;
    repeat (30) step();
    chk("pre-disable clk high", int'(bus.clk_o[0]), 1);
    bus.en_i = 2'b00;
    step();
    chk("disabled clk low", int'(bus.clk_o[0]), 0);
    chk("disabled tick low", int'(bus.tick_o[0]), 0);
    repeat (3) step();
    chk("disabled clk stays low", int'(bus.clk_o[0]), 0);
    chk("disabled active kept", int'(bus.active_div_o[0]), 50);
    bus.en_i = 2'b01;
    check_both(60, 50, 25, 50, 25, 2'b01, "re-enable");

    // Sync: ch0 D=10, ch1 D=7 running out of phase with each other
    program_div(2'b11, 16'd10, 16'd7);
    bus.en_i = 2'b11;
    repeat (13) step();
    chk("pre-sync ch1 high", int'(bus.clk_o[1]), 1);
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check_both(30, 10, 5, 7, 4, 2'b11, "sync");

    // Sync coinciding with a write on ch1: the new divisor is applied by that sync
    repeat (2) step();
    bus.sync_i = 1'b1;
    bus.div_i[1] = 16'd3;
    bus.div_valid_i = 2'b10;
    step();
    bus.sync_i = 1'b0;
    bus.div_valid_i = 2'b00;
    chk("sync+write active ch1", int'(bus.active_div_o[1]), 3);
    check_both(20, 10, 5, 3, 2, 2'b11, "sync+write");

    // Asynchronous reset mid-period
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset active ch1", int'(bus.active_div_o[1]), 50);
    chk("async reset clk_o", int'(bus.clk_o), 0);
    chk("async reset ready", int'(bus.div_ready_o), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
